// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP op encodings, scheduler states and default latencies
package fpu_pkg;
  localparam logic [2:0] FPU_ADD  = 3'd0;
  localparam logic [2:0] FPU_MUL  = 3'd1;
  localparam logic [2:0] FPU_DIV  = 3'd2;
  localparam logic [2:0] FPU_SQRT = 3'd3;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_t;
  localparam int DEF_ADD_LAT  = 1;
  localparam int DEF_MUL_LAT  = 4;
  localparam int DEF_DIV_LAT  = 8;
  localparam int DEF_SQRT_LAT = 16;
  localparam int DEF_CNT_W    = 5;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with one-hot grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic last_grant;
  // When both request, favour the one not granted last time
  always_comb gnt = (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
  // Remember who won, so reset leaves req0 first in line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= 1'b1;
    else if (accept) last_grant <= gnt[1];
endmodule

// File: rtl/fp_op_scheduler.sv
// fp_op_scheduler: shares one fp_alu between two requesters; define FPU_SQRT_EN to make op 3 (SQRT) legal
module fp_op_scheduler
  import fpu_pkg::*;
#(
  parameter int ADD_LAT  = DEF_ADD_LAT,
  parameter int MUL_LAT  = DEF_MUL_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int SQRT_LAT = DEF_SQRT_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_out,
  output logic        busy
);
  sched_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, lat_m1;
  logic [1:0] gnt;
  logic accept, sel_id, legal;
  logic [2:0] sel_op;
  logic [31:0] sel_a, sel_b;

  rr_arbiter2 u_arb (
    .clk    (cpu_clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .gnt    (gnt)
  );

  assign req0_ready = rst_n && state == IDLE && gnt[0];
  assign req1_ready = rst_n && state == IDLE && gnt[1];
  assign accept     = req0_ready | req1_ready;
  assign sel_id     = gnt[1];
  assign sel_op     = sel_id ? req1_op : req0_op;
  assign sel_a      = sel_id ? req1_a : req0_a;
  assign sel_b      = sel_id ? req1_b : req0_b;
  assign rsp_valid  = state == RESP;
  assign busy       = state != IDLE;

  // Decode legality and countdown preload of the granted op
  always_comb begin
`ifdef FPU_SQRT_EN
    legal = sel_op <= FPU_SQRT;
`else
    legal = sel_op <= FPU_DIV;
`endif
    lat_m1 = sel_op == FPU_ADD ? CNT_W'(ADD_LAT - 1) :
             sel_op == FPU_MUL ? CNT_W'(MUL_LAT - 1) :
             sel_op == FPU_DIV ? CNT_W'(DIV_LAT - 1) : CNT_W'(SQRT_LAT - 1);
  end

  // Next state: illegal ops skip the ALU and respond straight away
  always_comb begin
    state_nxt = state;
    if (state == IDLE && accept) state_nxt = legal ? EXEC : RESP;
    else if (state == EXEC && cnt == '0) state_nxt = RESP;
    else if (state == RESP && rsp_ready) state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge cpu_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;

  // Operand latch on accept, latency countdown, result capture
  always_ff @(posedge cpu_clk or negedge rst_n)
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      cnt      <= '0;
    end else if (state == IDLE && accept) begin
      alu_a    <= sel_a;
      alu_b    <= sel_b;
      alu_sel  <= sel_op;
      rsp_id   <= sel_id;
      rsp_data <= '0;
      rsp_err  <= !legal;
      cnt      <= lat_m1;
    end else if (state == EXEC) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        rsp_data <= alu_out;
        rsp_err  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_fp_op_scheduler.sv
// tb_fp_op_scheduler: scoreboard bench for fp_op_scheduler with a latency-aware fp_alu model
module tb_fp_op_scheduler;
  import fpu_pkg::*;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
    logic [15:0] lat;
  } rsp_t;

  logic        cpu_clk = 0, rst_n = 0;
  logic        req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic [2:0]  req0_op = 0, req1_op = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
  logic [31:0] rsp_data, alu_a, alu_b, alu_out;
  logic [2:0]  alu_sel;

  rsp_t sb[$];
  rsp_t obs_q[$];
  int   grants[$];
  int   age = 0, cyc = 0, last_acc = 0, rise_lat = 0;
  int   rd = 0, n_chk = 0, n_fail = 0;
  logic prev_rv = 0;

  fp_op_scheduler dut (
    .cpu_clk(cpu_clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .busy(busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic bit legal_op(logic [2:0] op);
`ifdef FPU_SQRT_EN
    return op <= 3'd3;
`else
    return op <= 3'd2;
`endif
  endfunction

  function automatic int lat_of(logic [2:0] op);
    if (!legal_op(op)) return 0;
    return op == 3'd0 ? DEF_ADD_LAT : op == 3'd1 ? DEF_MUL_LAT : op == 3'd2 ? DEF_DIV_LAT : DEF_SQRT_LAT;
  endfunction

  function automatic logic [31:0] alu_fn(logic [2:0] s, logic [31:0] a, logic [31:0] b);
    if (s == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return (a ^ {b[15:0], b[31:16]}) + {29'd0, s};
  endfunction

  function automatic rsp_t mk_exp(logic id, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    return '{id: id, data: legal_op(op) ? alu_fn(op, a, b) : 32'd0, err: !legal_op(op), lat: 16'(lat_of(op))};
  endfunction

  // ALU model: output is garbage until operands have been stable for the op's latency
  always_comb alu_out = (age >= lat_of(alu_sel) - 1) ? alu_fn(alu_sel, alu_a, alu_b) : 32'hDEADBEEF;

  always @(posedge cpu_clk) begin
    cyc <= cyc + 1;
    age <= ((req0_valid && req0_ready) || (req1_valid && req1_ready)) ? 0 : (age < 1000 ? age + 1 : age);
  end

  // Monitor: push expectations on accept, observed responses on handshake
  always @(negedge cpu_clk) begin
    if (!rst_n) begin
      prev_rv = 0;
      if (sb.size() > obs_q.size()) sb.pop_back();
    end else begin
      if (req0_valid && req0_ready) begin
        sb.push_back(mk_exp(1'b0, req0_op, req0_a, req0_b));
        grants.push_back(0);
        last_acc = cyc + 1;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(mk_exp(1'b1, req1_op, req1_a, req1_b));
        grants.push_back(1);
        last_acc = cyc + 1;
      end
      if (rsp_valid && !prev_rv) rise_lat = cyc - last_acc;
      if (rsp_valid && rsp_ready) obs_q.push_back('{id: rsp_id, data: rsp_data, err: rsp_err, lat: 16'(rise_lat)});
      prev_rv = rsp_valid;
    end
  end

  task automatic issue(input bit id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output bit ok);
    if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1; end
    else begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1; end
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge cpu_clk);
      ok = id ? req1_ready : req0_ready;
    end
    @(posedge cpu_clk); #1;
    if (id) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    for (int i = 0; i < 400 && obs_q.size() < rd + n; i++) @(negedge cpu_clk);
    ok = obs_q.size() >= rd + n;
    @(posedge cpu_clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; req0_valid = 1; req1_valid = 1;
    repeat (2) @(negedge cpu_clk);
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err, alu_a, alu_b, alu_sel, busy} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got valid=%0d id=%0d data=%h err=%0d a=%h b=%h sel=%0d busy=%0d, expected all 0",
                         rsp_valid, rsp_id, rsp_data, rsp_err, alu_a, alu_b, alu_sel, busy);
    end
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b, expected 00", {req1_ready, req0_ready});
    end
    req0_valid = 0; req1_valid = 0;
    @(posedge cpu_clk); #1; rst_n = 1;
    @(negedge cpu_clk);
    n_chk++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got busy=%0d valid=%0d, expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_add();
    int pulses;
    bit ok;
    @(posedge cpu_clk); #1;
    req0_op = FPU_ADD; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_valid = 1; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge cpu_clk);
      if (req0_ready) begin pulses++; @(posedge cpu_clk); #1; req0_valid = 0; end
    end
    n_chk++;
    if (pulses !== 1) begin n_fail++; $display("FAIL add_ready_pulses: got %0d, expected 1", pulses); end
    wait_obs(1, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL add_timeout: got %0d responses, expected 1", obs_q.size() - rd); end
    while (rd < obs_q.size() && rd < sb.size()) begin
      n_chk++;
      if (obs_q[rd] !== sb[rd]) begin
        n_fail++; $display("FAIL add_rsp: got id=%0d data=%h err=%0d lat=%0d, expected id=%0d data=%h err=%0d lat=%0d",
                           obs_q[rd].id, obs_q[rd].data, obs_q[rd].err, obs_q[rd].lat, sb[rd].id, sb[rd].data, sb[rd].err, sb[rd].lat);
      end
      rd++;
    end
  endtask

  task automatic test_div();
    bit ok;
    logic [31:0] a, b;
    a = 32'h41200000; b = 32'h40A00000;
    @(posedge cpu_clk); #1;
    rsp_ready = 0;
    issue(1'b1, FPU_DIV, a, b, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL div_grant: got no req1_ready, expected grant"); end
    for (int i = 0; i < 20; i++) begin
      @(negedge cpu_clk);
      if (rsp_valid) break;
      n_chk++;
      if (alu_sel !== FPU_DIV || alu_a !== a || alu_b !== b || busy !== 1'b1) begin
        n_fail++; $display("FAIL div_exec_hold: got sel=%0d a=%h b=%h busy=%0d, expected sel=2 a=%h b=%h busy=1",
                           alu_sel, alu_a, alu_b, busy, a, b);
      end
    end
    n_chk++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL div_resp_busy: got busy=%0d valid=%0d, expected 1 1", busy, rsp_valid);
    end
    @(posedge cpu_clk); #1; rsp_ready = 1;
    wait_obs(1, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL div_timeout: got %0d responses, expected 1", obs_q.size() - rd); end
    while (rd < obs_q.size() && rd < sb.size()) begin
      n_chk++;
      if (obs_q[rd] !== sb[rd]) begin
        n_fail++; $display("FAIL div_rsp: got id=%0d data=%h err=%0d lat=%0d, expected id=%0d data=%h err=%0d lat=%0d",
                           obs_q[rd].id, obs_q[rd].data, obs_q[rd].err, obs_q[rd].lat, sb[rd].id, sb[rd].data, sb[rd].err, sb[rd].lat);
      end
      rd++;
    end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL div_idle_busy: got %0d, expected 0", busy); end
  endtask

  task automatic test_alternate();
    int g0;
    bit ok;
    g0 = grants.size();
    @(posedge cpu_clk); #1;
    req0_op = FPU_ADD; req0_a = 32'h12345678; req0_b = 32'h0BADF00D; req0_valid = 1;
    req1_op = FPU_MUL; req1_a = 32'hCAFEBABE; req1_b = 32'h13572468; req1_valid = 1;
    for (int i = 0; i < 300 && grants.size() < g0 + 4; i++) begin @(posedge cpu_clk); #1; end
    req0_valid = 0; req1_valid = 0;
    n_chk++;
    if (grants.size() < g0 + 4) begin
      n_fail++; $display("FAIL alt_timeout: got %0d grants, expected 4", grants.size() - g0);
    end else begin
      n_chk++;
      if (grants[g0] !== 0) begin n_fail++; $display("FAIL alt_first: got requester %0d, expected 0", grants[g0]); end
      for (int i = 1; i < 4; i++) begin
        n_chk++;
        if (grants[g0 + i] === grants[g0 + i - 1]) begin
          n_fail++; $display("FAIL alt_order: grant %0d got requester %0d, expected %0d", i, grants[g0 + i], 1 - grants[g0 + i - 1]);
        end
      end
    end
    wait_obs(4, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL alt_rsp_timeout: got %0d responses, expected 4", obs_q.size() - rd); end
    while (rd < obs_q.size() && rd < sb.size()) begin
      n_chk++;
      if (obs_q[rd] !== sb[rd]) begin
        n_fail++; $display("FAIL alt_rsp: got id=%0d data=%h err=%0d lat=%0d, expected id=%0d data=%h err=%0d lat=%0d",
                           obs_q[rd].id, obs_q[rd].data, obs_q[rd].err, obs_q[rd].lat, sb[rd].id, sb[rd].data, sb[rd].err, sb[rd].lat);
      end
      rd++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rsp_t e;
    logic [31:0] a, b;
    a = 32'h3FC00000; b = 32'h40400000;
    e = mk_exp(1'b0, FPU_MUL, a, b);
    @(posedge cpu_clk); #1;
    rsp_ready = 0;
    req1_op = FPU_ADD; req1_a = 32'h00000011; req1_b = 32'h00000022; req1_valid = 1;
    issue(1'b0, FPU_MUL, a, b, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL bp_grant0: got no req0_ready, expected req0 granted first"); end
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge cpu_clk);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold: got valid=%0d data=%h id=%0d req1_ready=%0d, expected 1 %h 0 0",
                           rsp_valid, rsp_data, rsp_id, req1_ready, e.data);
      end
      @(negedge cpu_clk);
    end
    @(posedge cpu_clk); #1; rsp_ready = 1;
    @(negedge cpu_clk);
    n_chk++;
    if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_early_ready: got %0d, expected 0", req1_ready); end
    @(negedge cpu_clk);
    n_chk++;
    if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %0d, expected 1", req1_ready); end
    @(posedge cpu_clk); #1; req1_valid = 0;
    wait_obs(2, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout: got %0d responses, expected 2", obs_q.size() - rd); end
    while (rd < obs_q.size() && rd < sb.size()) begin
      n_chk++;
      if (obs_q[rd] !== sb[rd]) begin
        n_fail++; $display("FAIL bp_rsp: got id=%0d data=%h err=%0d lat=%0d, expected id=%0d data=%h err=%0d lat=%0d",
                           obs_q[rd].id, obs_q[rd].data, obs_q[rd].err, obs_q[rd].lat, sb[rd].id, sb[rd].data, sb[rd].err, sb[rd].lat);
      end
      rd++;
    end
  endtask

  task automatic test_illegal();
    bit ok;
    issue(1'b0, 3'd5, 32'hFFFF0000, 32'h0000FFFF, ok);
    wait_obs(1, ok);
    issue(1'b1, FPU_SQRT, 32'h40800000, 32'h00000000, ok);
    wait_obs(2, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL illegal_timeout: got %0d responses, expected 2", obs_q.size() - rd); end
    while (rd < obs_q.size() && rd < sb.size()) begin
      n_chk++;
      if (obs_q[rd] !== sb[rd]) begin
        n_fail++; $display("FAIL illegal_rsp: got id=%0d data=%h err=%0d lat=%0d, expected id=%0d data=%h err=%0d lat=%0d",
                           obs_q[rd].id, obs_q[rd].data, obs_q[rd].err, obs_q[rd].lat, sb[rd].id, sb[rd].data, sb[rd].err, sb[rd].lat);
      end
      rd++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    issue(1'b0, FPU_MUL, 32'h40000000, 32'h40000000, ok);
    @(negedge cpu_clk); @(negedge cpu_clk);
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err, alu_a, alu_b, alu_sel, busy, req0_ready, req1_ready} !== '0) begin
      n_fail++; $display("FAIL rmid_async: got valid=%0d data=%h a=%h b=%h sel=%0d busy=%0d, expected all 0",
                         rsp_valid, rsp_data, alu_a, alu_b, alu_sel, busy);
    end
    req0_op = FPU_ADD; req0_a = 32'h00000003; req0_b = 32'h00000005; req0_valid = 1;
    req1_op = FPU_MUL; req1_a = 32'h00000007; req1_b = 32'h00000009; req1_valid = 1;
    @(negedge cpu_clk);
    n_chk++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_ready_in_reset: got %b, expected 00", {req1_ready, req0_ready});
    end
    @(posedge cpu_clk); #1; rst_n = 1;
    @(negedge cpu_clk);
    n_chk++;
    if (rsp_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_after: got valid=%0d r0=%0d r1=%0d, expected 0 1 0", rsp_valid, req0_ready, req1_ready);
    end
    @(posedge cpu_clk); #1; req0_valid = 0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge cpu_clk); ok = req1_ready; end
    @(posedge cpu_clk); #1; req1_valid = 0;
    wait_obs(2, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rmid_timeout: got %0d responses, expected 2", obs_q.size() - rd); end
    while (rd < obs_q.size() && rd < sb.size()) begin
      n_chk++;
      if (obs_q[rd] !== sb[rd]) begin
        n_fail++; $display("FAIL rmid_rsp: got id=%0d data=%h err=%0d lat=%0d, expected id=%0d data=%h err=%0d lat=%0d",
                           obs_q[rd].id, obs_q[rd].data, obs_q[rd].err, obs_q[rd].lat, sb[rd].id, sb[rd].data, sb[rd].err, sb[rd].lat);
      end
      rd++;
    end
    n_chk++;
    if (sb.size() !== obs_q.size()) begin
      n_fail++; $display("FAIL rmid_leftover: got %0d responses, expected %0d", obs_q.size(), sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_alternate();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/fp_op_scheduler.md
Name: fp_op_scheduler

Overview:
- Sequencing controller that shares one fp_alu datapath (add.s/mul.s/div.s) between two requesters: the CPU FP issue port and the FP load/convert helper.
- Round-robin arbitrates, drives the ALU operands and selector, holds them stable for the op's latency, then captures the ALU result and returns it with the requester ID over a valid/ready response channel.
- One op in flight at a time.
- Sits between the FP issue logic and fp_alu.

Parameters:
ADD_LAT, 1, cycles from operand drive to valid alu_out for ADD (>=1)
MUL_LAT, 4, same for MUL (>=1)
DIV_LAT, 8, same for DIV (>=1)
SQRT_LAT, 16, same for SQRT (used only with FPU_SQRT_EN)
CNT_W, 5, latency counter width; must hold max(LAT)-1

Ports:
cpu_clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_op  in  3  0=ADD, 1=MUL, 2=DIV, 3=SQRT (feature-gated), others illegal
req0_a, req0_b  in  32  IEEE-754 single operands
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  requester that issued the op
rsp_data  out  32  result
rsp_err  out  1  op code was illegal
alu_a, alu_b  out  32  to fp_alu a/b
alu_sel  out  3  to fp_alu selector
alu_out  in  32  from fp_alu out
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; last_grant=1, so req0 wins first; all registered outputs 0 (rsp_valid, rsp_id, rsp_data, rsp_err, alu_a, alu_b, alu_sel, busy). reqN_ready is combinational and is therefore 0 during reset.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - Grant when any reqN_valid is high. If both are valid, grant the requester != last_grant. If one is valid, grant it.
  - reqN_ready=1 combinationally only for the granted requester, only in IDLE.
  - On the accept edge: latch op/a/b into alu_sel/alu_a/alu_b; latch id; update last_grant.
  - Legal op: cnt <= LAT(op)-1, go to EXEC.
  - Illegal op: rsp_data <= 0, rsp_err <= 1, go to RESP. The ALU is not exercised.
- EXEC:
  - alu_a, alu_b and alu_sel are held constant.
  - If cnt==0: rsp_data <= alu_out, rsp_err <= 0, go to RESP. Otherwise cnt <= cnt-1.
  - Result: rsp_valid rises exactly LAT(op) cycles after the accept edge.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable until the handshake.
  - On rsp_valid && rsp_ready: go to IDLE, rsp_valid <= 0. A new grant is possible on the following cycle.
  - Back-to-back throughput with rsp_ready tied high: one op per LAT+2 cycles.
- No reqN_ready is asserted in EXEC or RESP. Requesters must hold valid/op/operands stable until ready.
- alu_* retain their last values in IDLE; they are not cleared.
- Reset mid-EXEC or mid-RESP: the op and its result are discarded and the state returns to IDLE with reset values. There is no replay.
- rsp_ready while not in RESP is ignored.

Optional Feature:
- Macro FPU_SQRT_EN.
- Defined: op 3 is legal, with latency SQRT_LAT and alu_sel=3.
- Undefined: op 3 is illegal and takes the rsp_err path; SQRT_LAT is unused.

Decomposition:
- Shared package fpu_pkg holds:
  - op encodings FPU_ADD=0, FPU_MUL=1, FPU_DIV=2, FPU_SQRT=3; fp_alu uses the same constants.
  - state encoding IDLE/EXEC/RESP.
  - default latency constants.
- One natural sub-module, rr_arbiter2: two requests, last_grant state, one-hot grant output.
- The FSM and latency counter stay in fp_op_scheduler.

Test Plan:
- Reset, then req0 ADD with a=0x3F800000, b=0x40000000; ALU model returns 0x40400000 -> req0_ready pulses once; rsp_valid rises 1 cycle after accept; rsp_data=0x40400000, rsp_id=0, rsp_err=0.
- req1 DIV, DIV_LAT=8 -> rsp_valid rises exactly 8 cycles after accept; alu_sel=2 and alu_a/alu_b constant throughout EXEC; busy=1 until handshake.
- Both requesters valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1; no requester is granted twice consecutively while the other is waiting.
- rsp_ready held low 5 cycles after rsp_valid -> rsp_data/rsp_id stable; req1_valid held high gets no ready until 1 cycle after the handshake.
- req0_op=5, and op=3 without FPU_SQRT_EN -> rsp_valid the next cycle with rsp_err=1, rsp_data=0; with FPU_SQRT_EN, op=3 takes SQRT_LAT cycles with rsp_err=0.
- rst_n asserted mid-EXEC of a MUL -> all outputs 0 immediately (asynchronously); after release, no stale rsp_valid; req0 granted first.
